// File: rtl/alu_op_sequencer.sv
// Request/response sequencer for the combinational 64-bit ALU: launches registered operands,
// waits a fixed settle window, captures result and NZCV, and keeps the architectural flag register.
module alu_op_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int DATA_W        = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [2:0]        req_cntrl,
    input  logic              req_set_flags,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_cntrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_result,
    output logic [3:0]        resp_flags,
    output logic              resp_err,
    output logic [3:0]        flags_q,
    output logic              busy
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  alu_a_q, alu_a_d;
    logic [DATA_W-1:0]  alu_b_q, alu_b_d;
    logic [2:0]         alu_cntrl_q, alu_cntrl_d;
    logic               set_flags_q, set_flags_d;
    logic               resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]  resp_result_q, resp_result_d;
    logic [3:0]         resp_flags_q, resp_flags_d;
    logic               resp_err_q, resp_err_d;
    logic [3:0]         nzcv_q, nzcv_d;

    // 001 and 111 have no ALU meaning; they are answered with an error and never launched.
    function automatic logic cntrl_legal(input logic [2:0] c);
        return (c != 3'b001) && (c != 3'b111);
    endfunction

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_cntrl_d   = alu_cntrl_q;
        set_flags_d   = set_flags_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        resp_flags_d  = resp_flags_q;
        resp_err_d    = resp_err_q;
        nzcv_d        = nzcv_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (cntrl_legal(req_cntrl)) begin
                        alu_a_d     = req_a;
                        alu_b_d     = req_b;
                        alu_cntrl_d = req_cntrl;
                        set_flags_d = req_set_flags;
                        cnt_d       = CNT_W'(SETTLE_CYCLES - 1);
                        state_d     = SETTLE;
                    end else begin
                        resp_valid_d  = 1'b1;
                        resp_result_d = '0;
                        resp_flags_d  = 4'b0000;
                        resp_err_d    = 1'b1;
                        state_d       = RESP;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    resp_valid_d  = 1'b1;
                    resp_result_d = alu_result;
                    resp_flags_d  = alu_flags;
                    resp_err_d    = 1'b0;
                    if (set_flags_q) begin
                        nzcv_d = alu_flags;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_cntrl_q   <= 3'b000;
            set_flags_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            resp_flags_q  <= 4'b0000;
            resp_err_q    <= 1'b0;
            nzcv_q        <= 4'b0000;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_cntrl_q   <= alu_cntrl_d;
            set_flags_q   <= set_flags_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_flags_q  <= resp_flags_d;
            resp_err_q    <= resp_err_d;
            nzcv_q        <= nzcv_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_cntrl   = alu_cntrl_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_flags  = resp_flags_q;
    assign resp_err    = resp_err_q;
    assign flags_q     = nzcv_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 64-bit ALU answering the launched operands.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [2:0]  req_cntrl;
    logic        req_set_flags;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [2:0]  alu_cntrl;
    logic [63:0] alu_result;
    logic [3:0]  alu_flags;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_result;
    logic [3:0]  resp_flags;
    logic        resp_err;
    logic [3:0]  flags_q;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.SETTLE_CYCLES(4), .DATA_W(64)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_cntrl    (req_cntrl),
        .req_set_flags(req_set_flags),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_cntrl    (alu_cntrl),
        .alu_result   (alu_result),
        .alu_flags    (alu_flags),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_result  (resp_result),
        .resp_flags   (resp_flags),
        .resp_err     (resp_err),
        .flags_q      (flags_q),
        .busy         (busy)
    );

    // Reference ALU: {N,Z,C,V}; subtraction carry is "no borrow".
    logic [64:0] ext;
    logic        c_bit, v_bit;
    always_comb begin
        ext        = '0;
        c_bit      = 1'b0;
        v_bit      = 1'b0;
        alu_result = '0;
        case (alu_cntrl)
            3'b000: alu_result = alu_b;
            3'b010: begin
                ext        = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = ext[63:0];
                c_bit      = ext[64];
                v_bit      = (alu_a[63] == alu_b[63]) && (alu_result[63] != alu_a[63]);
            end
            3'b011: begin
                ext        = {1'b0, alu_a} + {1'b0, ~alu_b} + 65'd1;
                alu_result = ext[63:0];
                c_bit      = ext[64];
                v_bit      = (alu_a[63] != alu_b[63]) && (alu_result[63] != alu_a[63]);
            end
            3'b100: alu_result = alu_a & alu_b;
            3'b101: alu_result = alu_a | alu_b;
            3'b110: alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
        alu_flags = {alu_result[63], (alu_result == 64'd0), c_bit, v_bit};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and consumes the accepting edge.
    task automatic issue(input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] c, input logic sf);
        req_valid     = 1'b1;
        req_a         = a;
        req_b         = b;
        req_cntrl     = c;
        req_set_flags = sf;
        tick();
        req_valid     = 1'b0;
    endtask

    // Three edges inside the settle window with no response, then the capturing edge.
    task automatic settle(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_settle_rv"}, 64'(resp_valid), 64'd0);
            tick();
        end
        chk({tag, "_settle_rv_last"}, 64'(resp_valid), 64'd0);
        tick();
        chk({tag, "_rv"}, 64'(resp_valid), 64'd1);
    endtask

    logic [63:0] held_res;

    initial begin
        reset_n       = 1'b0;
        req_valid     = 1'b0;
        req_a         = '0;
        req_b         = '0;
        req_cntrl     = 3'b000;
        req_set_flags = 1'b0;
        resp_ready    = 1'b1;
        #12;
        chk("rst_alu_a",  alu_a, 64'd0);
        chk("rst_cntrl",  64'(alu_cntrl), 64'd0);
        chk("rst_rv",     64'(resp_valid), 64'd0);
        chk("rst_flags",  64'(flags_q), 64'd0);
        reset_n = 1'b1;
        tick();
        chk("rst_ready",  64'(req_ready), 64'd1);
        chk("rst_busy",   64'(busy), 64'd0);

        // 1: 5+5 with flag update
        issue(64'd5, 64'd5, 3'b010, 1'b1);
        chk("t1_ready", 64'(req_ready), 64'd0);
        chk("t1_alu_a", alu_a, 64'd5);
        settle("t1");
        chk("t1_res",   resp_result, 64'd10);
        chk("t1_rflg",  64'(resp_flags), 64'h0);
        chk("t1_fq",    64'(flags_q), 64'h0);
        chk("t1_err",   64'(resp_err), 64'd0);
        tick();
        chk("t1_idle",  64'(req_ready), 64'd1);

        // 2: 5-5 gives Z and C (no borrow)
        issue(64'd5, 64'd5, 3'b011, 1'b1);
        settle("t2");
        chk("t2_res",   resp_result, 64'd0);
        chk("t2_rflg",  64'(resp_flags), 64'h6);
        chk("t2_fq",    64'(flags_q), 64'h6);
        tick();

        // 3: signed overflow, flags register left alone
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b0);
        settle("t3");
        chk("t3_res",   resp_result, 64'h8000_0000_0000_0000);
        chk("t3_rflg",  64'(resp_flags), 64'h9);
        chk("t3_fq",    64'(flags_q), 64'h6);
        tick();

        // 4: illegal control answered on the next edge
        issue(64'd3, 64'd4, 3'b001, 1'b1);
        chk("t4_rv",    64'(resp_valid), 64'd1);
        chk("t4_err",   64'(resp_err), 64'd1);
        chk("t4_res",   resp_result, 64'd0);
        chk("t4_rflg",  64'(resp_flags), 64'h0);
        chk("t4_fq",    64'(flags_q), 64'h6);
        chk("t4_cntrl", 64'(alu_cntrl), 64'h2);
        chk("t4_alu_a", alu_a, 64'h7FFF_FFFF_FFFF_FFFF);
        tick();
        chk("t4_idle",  64'(req_ready), 64'd1);

        // 5: back-pressure on the response, competing request must be ignored
        resp_ready = 1'b0;
        issue(64'hF0F0, 64'hFF00, 3'b100, 1'b0);
        settle("t5");
        held_res = resp_result;
        chk("t5_res",   resp_result, 64'hF000);
        req_valid = 1'b1;
        req_a     = 64'h1234;
        req_b     = 64'h0F0F;
        req_cntrl = 3'b101;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_hold_rv",  64'(resp_valid), 64'd1);
            chk("t5_hold_res", resp_result, held_res);
            chk("t5_hold_rdy", 64'(req_ready), 64'd0);
        end
        chk("t5_hold_alu", alu_a, 64'hF0F0);
        resp_ready = 1'b1;
        tick();
        chk("t5_hs_rv",  64'(resp_valid), 64'd0);
        chk("t5_hs_rdy", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        chk("t5_acc_busy", 64'(busy), 64'd1);
        chk("t5_acc_a",    alu_a, 64'h1234);
        settle("t5b");
        chk("t5b_res", resp_result, 64'h1F3F);
        tick();

        // 6: reset during the settle window aborts the op
        issue(64'd9, 64'd2, 3'b011, 1'b1);
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("t6_fq",   64'(flags_q), 64'h0);
        chk("t6_rv",   64'(resp_valid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        tick();
        reset_n = 1'b1;
        chk("t6_rdy",  64'(req_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_no_rv", 64'(resp_valid), 64'd0);
        end
        chk("t6_fq_end", 64'(flags_q), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
